hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised pipeline hazard unit for the TSC pipelined CPU, sitting beside the IF/ID/EX/MEM/WB registers in `cpu.v`. It replaces pure address-compare detection with a per-register scoreboard of in-flight writes and in-flight loads. This lets it cover variable-latency cache misses and configurable forwarding. It also sequences control-hazard flushes and generates all stall and flush enables.

## Interface
- `REG_ADDR_W`, 2: register address width; NUM_REGS = 2**REG_ADDR_W.
- `WORD_W`, 16: PC width.
- `CNT_W`, 2: width of each per-register in-flight counter; saturates at 2**CNT_W-1.
- `FWD_MODE`, 1: 0 = no forwarding, 1 = full forwarding (only load-use stalls).
- `RF_SELF_FWD`, 1: 1 = register file forwards a WB write to a same-cycle read.
---
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: **synchronous, active-low reset**.
- `if_data_ready` in 1: instruction fetch complete.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_used`, `id_rt_used` in 1: ID reads rs / rt.
- `id_rs`, `id_rt`, `id_wr_addr` in REG_ADDR_W: ID source and destination registers.
- `id_regwrite`, `id_is_load` in 1: ID writes a register; ID is LWD.
- `id_is_jump` in 1: ID is JMP/JAL/JPR/JRL.
- `id_correct_pc`, `if_pc`, `id_pc`, `ex_correct_pc` in WORD_W: PCs used for redirect checks.
- `ex_is_branch` in 1: EX holds a conditional branch.
- `mem_is_mem`, `mem_data_ready` in 1: MEM accesses memory; data access complete.
- `mem_load_done` in 1 / `mem_load_addr` in REG_ADDR_W: load data returned this cycle, and its destination.
- `wb_regwrite` in 1 / `wb_wr_addr` in REG_ADDR_W: WB retires a register write.
- `stall_if`, `stall_id`, `stall_mem` out 1: hold the IF/ID/MEM pipeline registers.
- `flush_ifid`, `flush_idex` out 1: insert a bubble into IF/ID or ID/EX.
- `redirect` out 2: 00 none, 01 branch target (EX), 10 jump target (ID).
- `sb_error` out 1: sticky flag for a counter underflow or overflow.

## Operation
- **Scoreboard.**
  - Per register: `wr_cnt[r]` counts issued, unretired writes; `ld_cnt[r]` counts issued loads whose data has not returned.
  - Issue happens when `id_valid & ~stall_id & ~stall_mem & ~flush_idex`.
  - On issue with `id_regwrite`: `wr_cnt[id_wr_addr]++`. If also `id_is_load`: `ld_cnt[id_wr_addr]++`.
  - On `wb_regwrite`: `wr_cnt[wb_wr_addr]--`. On `mem_load_done`: `ld_cnt[mem_load_addr]--`.
  - Increment and decrement of the same counter in the same cycle leaves it unchanged.
  - Decrement at 0 holds 0 and sets `sb_error`. Increment at max holds max and sets `sb_error`.
- **Source hazard per used source s.**
  - FWD_MODE=0: hazard if `wr_cnt[s]!=0`. Exception: no hazard when RF_SELF_FWD=1, `wr_cnt[s]==1`, and WB retires s this cycle.
  - FWD_MODE=1: hazard if `ld_cnt[s]!=0`. Exception: no hazard when `ld_cnt[s]==1` and `mem_load_done` targets s this cycle.
  - `id_data_hazard` = rs hazard | rt hazard.
- **Mem hazard:** `mem_is_mem & ~mem_data_ready`. Freezes the whole pipeline: `stall_if`, `stall_id`, `stall_mem` all asserted; no flush and no redirect are issued that cycle.
- **Control hazards.**
  - `branch_fail = ex_is_branch & (ex_correct_pc != id_pc)`.
  - `jump_fail = id_valid & id_is_jump & (id_correct_pc != if_pc)`.
  - Branch has priority over jump because it is the older instruction.
- **FSM (states RUN, REDIRECT):**
  - RUN → REDIRECT on `branch_fail` or `jump_fail` when no mem hazard. That cycle: set `redirect`, `flush_ifid`=1, and `flush_idex`=1 for branch only. A jump's ID instruction proceeds.
  - REDIRECT: `flush_ifid` is held for 1 further cycle, then returns to RUN. Holding continues while `~if_data_ready`, so a stale in-flight fetch is discarded.
  - A new `branch_fail` in REDIRECT is not possible, since EX holds a bubble. Any jump in REDIRECT is ignored.
- **Stalls in RUN without a mem hazard:**
  - `id_data_hazard` → `stall_if`, `stall_id`, `flush_idex`.
  - `~if_data_ready` → `flush_ifid`.
- **Reset** (`reset_n`=0 at a rising edge): clears all counters, sets state to RUN, and clears `sb_error`. Until the first edge after reset, outputs follow the combinational rules on the cleared state. Reset mid-miss discards all in-flight state.

## Timing
- Hazard, stall, flush and redirect outputs are combinational from the inputs and registered state, valid in the same cycle.
- Counters and FSM update at the rising edge.
- Load-use in FWD_MODE=1 costs exactly 1 bubble on a cache hit, and 1 + miss cycles otherwise.
- Branch mispredict costs 2 bubbles; jump mispredict costs 1, plus any extra fetch-wait cycles in REDIRECT.

## Configuration
- `HAZARD_PERF_EN` defined: three 16-bit wrapping counters are compiled in, exposed as outputs `perf_data_stall`, `perf_mem_stall`, `perf_ctrl_flush`. They count cycles with an ID data hazard, with a mem hazard, and with redirect!=0. All are cleared by reset.
- Undefined: the counters and their ports are absent. Other behaviour is identical.

## Structure
- Shared package/`opcodes.v` holds: redirect encodings, FSM state encodings, and the FWD_MODE value constants.
- One sub-module, `reg_inflight_cnt`: a saturating up/down counter with an error output, instantiated 2×NUM_REGS times.

## Test plan
- LWD $1 issued, ADD reading $1 next, FWD_MODE=1, hit → exactly 1 cycle of `stall_id`+`flush_idex`, then issue; `ld_cnt[1]` returns to 0.
- Same case with a 4-cycle miss → `stall_mem` for 4 cycles with no flush; the data stall resolves on the `mem_load_done` cycle.
- FWD_MODE=0, ADD $2 followed by SUB reading $2 → stall until WB retires; with RF_SELF_FWD=1, issue occurs in the WB cycle.
- Branch in EX with `ex_correct_pc`=0x0010 and `id_pc`=0x0002, while ID holds JMP → `redirect`=01, `flush_ifid`=1, `flush_idex`=1, and the jump is ignored.
- WB retire to $3 while `wr_cnt[3]`=0 → counter stays 0 and `sb_error`=1 until reset.
- Reset asserted mid-miss with counters nonzero → next cycle all counters are 0, state is RUN, and there are no stalls.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: redirect codes, FSM states and
// forwarding-mode constants.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'b00,
    REDIR_BRANCH = 2'b01,
    REDIR_JUMP   = 2'b10
  } redirect_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } hz_state_e;

  localparam int FWD_NONE = 0;
  localparam int FWD_FULL = 1;

endpackage

// File: rtl/hazard_scoreboard_reg_inflight_cnt.sv
// reg_inflight_cnt: saturating up/down counter of in-flight operations on one
// register; err pulses when an update would underflow or overflow.
module reg_inflight_cnt
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Simultaneous inc and dec cancel, so neither boundary can be crossed.
  always_comb begin
    count_next = count_reg;
    err        = 1'b0;
    if (inc && !dec) begin
      if (count_reg == CNT_MAX) err = 1'b1;
      else                      count_next = count_reg + 1'b1;
    end else if (dec && !inc) begin
      if (count_reg == '0) err = 1'b1;
      else                 count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) count_reg <= '0;
    else          count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register scoreboard of in-flight writes/loads plus
// control-redirect sequencing. Optional perf counters under HAZARD_PERF_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter int WORD_W      = 16,
  parameter int CNT_W       = 2,
  parameter int FWD_MODE    = 1,
  parameter int RF_SELF_FWD = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_data_ready,
  input  logic                  id_valid,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  id_is_jump,
  input  logic [WORD_W-1:0]     id_correct_pc,
  input  logic [WORD_W-1:0]     if_pc,
  input  logic [WORD_W-1:0]     id_pc,
  input  logic [WORD_W-1:0]     ex_correct_pc,
  input  logic                  ex_is_branch,
  input  logic                  mem_is_mem,
  input  logic                  mem_data_ready,
  input  logic                  mem_load_done,
  input  logic [REG_ADDR_W-1:0] mem_load_addr,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_wr_addr,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_mem,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic [1:0]            redirect,
  output logic                  sb_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]           perf_data_stall,
  output logic [15:0]           perf_mem_stall,
  output logic [15:0]           perf_ctrl_flush
`endif
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic [CNT_W-1:0]    wr_cnt [NUM_REGS];
  logic [CNT_W-1:0]    ld_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] wr_err;
  logic [NUM_REGS-1:0] ld_err;

  hz_state_e state_reg;
  hz_state_e state_next;
  redirect_e redirect_sel;
  logic      sb_error_reg;
  logic      issue;
  logic      mem_hazard, branch_fail, jump_fail;
  logic      rs_hazard, rt_hazard, id_data_hazard;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic wr_inc, wr_dec, ld_inc, ld_dec;
      assign wr_inc = issue && id_regwrite && (id_wr_addr == REG_ADDR_W'(gi));
      assign wr_dec = wb_regwrite && (wb_wr_addr == REG_ADDR_W'(gi));
      assign ld_inc = wr_inc && id_is_load;
      assign ld_dec = mem_load_done && (mem_load_addr == REG_ADDR_W'(gi));

      reg_inflight_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (wr_inc),
        .dec     (wr_dec),
        .count   (wr_cnt[gi]),
        .err     (wr_err[gi])
      );

      reg_inflight_cnt #(.CNT_W(CNT_W)) u_ld_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (ld_inc),
        .dec     (ld_dec),
        .count   (ld_cnt[gi]),
        .err     (ld_err[gi])
      );
    end
  endgenerate

  // A source is busy while producers are pending, unless the last one
  // delivers its value in this very cycle.
  function automatic logic pending(input logic [CNT_W-1:0] cnt, input logic retiring);
    return (cnt != '0) && !((cnt == CNT_W'(1)) && retiring);
  endfunction

  always_comb begin
    if (FWD_MODE == FWD_NONE) begin
      rs_hazard = pending(wr_cnt[id_rs],
                          (RF_SELF_FWD != 0) && wb_regwrite && (wb_wr_addr == id_rs));
      rt_hazard = pending(wr_cnt[id_rt],
                          (RF_SELF_FWD != 0) && wb_regwrite && (wb_wr_addr == id_rt));
    end else begin
      rs_hazard = pending(ld_cnt[id_rs], mem_load_done && (mem_load_addr == id_rs));
      rt_hazard = pending(ld_cnt[id_rt], mem_load_done && (mem_load_addr == id_rt));
    end
  end

  assign id_data_hazard = (id_rs_used && rs_hazard) || (id_rt_used && rt_hazard);
  assign mem_hazard     = mem_is_mem && !mem_data_ready;
  assign branch_fail    = ex_is_branch && (ex_correct_pc != id_pc);
  assign jump_fail      = id_valid && id_is_jump && (id_correct_pc != if_pc);

  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_mem    = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    redirect_sel = REDIR_NONE;
    state_next   = state_reg;
    if (mem_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_mem = 1'b1;
    end else if (state_reg == ST_RUN) begin
      // Branch is older than the jump in ID, so it wins.
      if (branch_fail) begin
        redirect_sel = REDIR_BRANCH;
        flush_ifid   = 1'b1;
        flush_idex   = 1'b1;
        state_next   = ST_REDIRECT;
      end else if (jump_fail) begin
        redirect_sel = REDIR_JUMP;
        flush_ifid   = 1'b1;
        state_next   = ST_REDIRECT;
      end
      if (id_data_hazard) begin
        stall_if   = 1'b1;
        stall_id   = 1'b1;
        flush_idex = 1'b1;
      end
      if (!if_data_ready) flush_ifid = 1'b1;
    end else begin
      // Keep squashing IF/ID until the fetch from the new target lands.
      flush_ifid = 1'b1;
      if (if_data_ready) state_next = ST_RUN;
    end
  end

  assign issue    = id_valid && !stall_id && !stall_mem && !flush_idex;
  assign redirect = redirect_sel;
  assign sb_error = sb_error_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_RUN;
      sb_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (|{wr_err, ld_err}) sb_error_reg <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_data_reg, perf_mem_reg, perf_ctrl_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_data_reg <= '0;
      perf_mem_reg  <= '0;
      perf_ctrl_reg <= '0;
    end else begin
      if (id_data_hazard)             perf_data_reg <= perf_data_reg + 16'd1;
      if (mem_hazard)                 perf_mem_reg  <= perf_mem_reg + 16'd1;
      if (redirect_sel != REDIR_NONE) perf_ctrl_reg <= perf_ctrl_reg + 16'd1;
    end
  end

  assign perf_data_stall = perf_data_reg;
  assign perf_mem_stall  = perf_mem_reg;
  assign perf_ctrl_flush = perf_ctrl_reg;
`endif

endmodule
